// File: rtl/axi_bw_resp_scheduler_pkg.sv
// axi_bw_sched_pkg: shared B-channel response codes and scheduler FSM state type
package axi_bw_sched_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} bw_sched_state_t;
endpackage

// File: rtl/axi_bw_resp_scheduler_if.sv
// axi_bw_resp_scheduler_if: B-channel, AW-credit and decode-error signals of the scheduler
// slave modport is the scheduler side, master modport drives it (responders, master, AW/W logic).
interface axi_bw_resp_scheduler_if #(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_USER_W  = 6
);
  logic [N_INIT_PORT-1:0][AXI_ID_IN-1:0]  bid_i;
  logic [N_INIT_PORT-1:0][1:0]            bresp_i;
  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0] buser_i;
  logic [N_INIT_PORT-1:0]                 bvalid_i;
  logic [N_INIT_PORT-1:0]                 bready_o;
  logic [AXI_ID_IN-1:0]                   bid_o;
  logic [1:0]                             bresp_o;
  logic [AXI_USER_W-1:0]                  buser_o;
  logic                                   bvalid_o;
  logic                                   bready_i;
  logic                                   aw_issue_i;
  logic [$clog2(N_INIT_PORT)-1:0]         aw_target_i;
  logic [N_INIT_PORT-1:0]                 aw_stall_o;
  logic                                   err_push_i;
  logic [AXI_ID_IN-1:0]                   err_id_i;
  logic [AXI_USER_W-1:0]                  err_user_i;
  logic                                   err_full_o;
  logic                                   outst_any_o;
  logic                                   proto_err_o;
  modport slave (
    input  bid_i, bresp_i, buser_i, bvalid_i, bready_i, aw_issue_i, aw_target_i,
           err_push_i, err_id_i, err_user_i,
    output bready_o, bid_o, bresp_o, buser_o, bvalid_o, aw_stall_o, err_full_o,
           outst_any_o, proto_err_o
  );
  modport master (
    output bid_i, bresp_i, buser_i, bvalid_i, bready_i, aw_issue_i, aw_target_i,
           err_push_i, err_id_i, err_user_i,
    input  bready_o, bid_o, bresp_o, buser_o, bvalid_o, aw_stall_o, err_full_o,
           outst_any_o, proto_err_o
  );
endinterface

// File: rtl/axi_bw_err_fifo.sv
// axi_bw_err_fifo: decode-error {id,user} entry FIFO
// Ports: clk, rst_n (async, active-low); push/din write; pop/dout read head;
// full/empty status; drop flags a push lost because the FIFO was full without a pop.
module axi_bw_err_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic         w_wr, w_rd;
  assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign empty = r_wp == r_rp;
  // A pop frees the slot the push lands in, so push+pop while full both proceed.
  assign w_wr  = push & (~full | pop);
  assign w_rd  = pop & ~empty;
  assign drop  = push & full & ~pop;
  assign dout  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= din;
endmodule

// File: rtl/axi_bw_resp_scheduler.sv
// axi_bw_resp_scheduler: round-robin B-channel scheduler with per-port write credit and DECERR sequencing
// Ports: clk, rst_n (async, active-low); bus (slave modport) carries responder B inputs,
// scheduled B output, AW issue/stall credit, decode-error push and status flags.
module axi_bw_resp_scheduler
  import axi_bw_sched_pkg::*;
#(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_USER_W  = 6,
  parameter int MAX_OUTST   = 16,
  parameter int ERR_DEPTH   = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  axi_bw_resp_scheduler_if.slave   bus
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int RW = $clog2(N_INIT_PORT + 1);
  localparam int TW = $clog2(N_INIT_PORT);
  bw_sched_state_t                r_state;
  logic [RW-1:0]                  r_rr, r_gnt, w_pick, w_gnt, w_nxt;
  logic [N_INIT_PORT-1:0][CW-1:0] r_cnt;
  logic                           r_proto;
  logic [N_INIT_PORT:0]           w_req;
  logic                           w_any, w_valid, w_hs, w_pop, w_empty, w_drop, w_perr;
  logic [AXI_ID_IN-1:0]           w_hid;
  logic [AXI_USER_W-1:0]          w_huser;
  logic [N_INIT_PORT-1:0]         w_inc, w_dec;
  int                             idx;
  axi_bw_err_fifo #(.DEPTH(ERR_DEPTH), .W(AXI_ID_IN + AXI_USER_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(bus.err_push_i), .din({bus.err_id_i, bus.err_user_i}),
    .pop(w_pop), .dout({w_hid, w_huser}), .full(bus.err_full_o), .empty(w_empty), .drop(w_drop)
  );
  assign bus.outst_any_o = |r_cnt;
  assign bus.proto_err_o = r_proto;
  // DECERR may only go out once every real response ahead of it has drained.
  assign w_req   = {~w_empty & ~bus.outst_any_o, bus.bvalid_i};
  assign w_gnt   = (r_state == HOLD) ? r_gnt : w_pick;
  assign w_valid = (r_state == HOLD) | w_any;
  assign w_hs    = w_valid & bus.bready_i;
  assign w_pop   = w_hs & (w_gnt == RW'(N_INIT_PORT));
  assign w_nxt   = (w_gnt == RW'(N_INIT_PORT)) ? '0 : w_gnt + 1'b1;
  assign bus.bvalid_o = w_valid;
  // Descending walk so the lowest offset from rr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    idx    = 0;
    for (int k = N_INIT_PORT; k >= 0; k--) begin
      idx = int'(r_rr) + k;
      if (idx > N_INIT_PORT) idx = idx - (N_INIT_PORT + 1);
      if (w_req[idx]) begin
        w_any  = 1'b1;
        w_pick = RW'(idx);
      end
    end
  end
  always_comb begin
    bus.bid_o    = '0;
    bus.bresp_o  = '0;
    bus.buser_o  = '0;
    bus.bready_o = '0;
    w_perr       = w_drop;
    if (w_valid && w_gnt == RW'(N_INIT_PORT)) begin
      bus.bid_o   = w_hid;
      bus.bresp_o = RESP_DECERR;
      bus.buser_o = w_huser;
    end
    for (int i = 0; i < N_INIT_PORT; i++) begin
      if (w_valid && w_gnt == RW'(i)) begin
        bus.bid_o       = bus.bid_i[i];
        bus.bresp_o     = bus.bresp_i[i];
        bus.buser_o     = bus.buser_i[i];
        bus.bready_o[i] = bus.bready_i;
      end
      w_inc[i] = bus.aw_issue_i & (bus.aw_target_i == TW'(i));
      w_dec[i] = w_hs & (w_gnt == RW'(i));
      bus.aw_stall_o[i] = r_cnt[i] == CW'(MAX_OUTST);
      if (w_inc[i] & ~w_dec[i] & (r_cnt[i] == CW'(MAX_OUTST))) w_perr = 1'b1;
      if (w_dec[i] & ~w_inc[i] & (r_cnt[i] == '0)) w_perr = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_proto <= 1'b0;
    end else begin
      r_proto <= r_proto | w_perr;
      if (w_hs) r_rr <= w_nxt;
      if (r_state == IDLE && w_any && !bus.bready_i) begin
        r_state <= HOLD;
        r_gnt   <= w_pick;
      end else if (r_state == HOLD && bus.bready_i) r_state <= IDLE;
      for (int i = 0; i < N_INIT_PORT; i++)
        if (w_inc[i] & ~w_dec[i] & (r_cnt[i] != CW'(MAX_OUTST))) r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] & ~w_inc[i] & (r_cnt[i] != '0)) r_cnt[i] <= r_cnt[i] - 1'b1;
    end
endmodule

// File: tb/tb_axi_bw_resp_scheduler.sv
// tb_axi_bw_resp_scheduler: directed self-checking bench for axi_bw_resp_scheduler
module tb_axi_bw_resp_scheduler;
  import axi_bw_sched_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  axi_bw_resp_scheduler_if #(.N_INIT_PORT(4), .AXI_ID_IN(16), .AXI_USER_W(6)) bus ();
  axi_bw_resp_scheduler #(
    .N_INIT_PORT(4), .AXI_ID_IN(16), .AXI_USER_W(6), .MAX_OUTST(16), .ERR_DEPTH(4)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.bid_i = '0; bus.bresp_i = '0; bus.buser_i = '0; bus.bvalid_i = '0; bus.bready_i = 0;
    bus.aw_issue_i = 0; bus.aw_target_i = '0; bus.err_push_i = 0; bus.err_id_i = '0; bus.err_user_i = '0;
    step(); step();
    chk("rst_bvalid", bus.bvalid_o, 0);
    chk("rst_bready", bus.bready_o, 0);
    chk("rst_bid", bus.bid_o, 0);
    chk("rst_stall", bus.aw_stall_o, 0);
    chk("rst_full", bus.err_full_o, 0);
    chk("rst_outst", bus.outst_any_o, 0);
    chk("rst_proto", bus.proto_err_o, 0);
    rst_n = 1;
    step();
    // two AW each to ports 0 and 2
    bus.aw_issue_i = 1; bus.aw_target_i = 0; step(); step();
    bus.aw_target_i = 2; step(); step();
    bus.aw_issue_i = 0;
    chk("a_cnt0", dut.r_cnt[0], 2);
    chk("a_cnt2", dut.r_cnt[2], 2);
    chk("a_outst", bus.outst_any_o, 1);
    // bvalid 0101 with bready: grant 0 then 2
    bus.bid_i[0] = 16'h0011; bus.bid_i[2] = 16'h0022; bus.bvalid_i = 4'b0101; bus.bready_i = 1;
    #1;
    chk("a_bid0", bus.bid_o, 16'h0011);
    chk("a_brdy0", bus.bready_o, 4'b0001);
    step();
    chk("a_bid2", bus.bid_o, 16'h0022);
    chk("a_brdy2", bus.bready_o, 4'b0100);
    step();
    bus.bvalid_i = '0; bus.bready_i = 0;
    chk("a_rr", dut.r_rr, 3);
    chk("a_cnt0b", dut.r_cnt[0], 1);
    chk("a_cnt2b", dut.r_cnt[2], 1);
    // HOLD on port 1 while port 0 joins later
    bus.aw_issue_i = 1; bus.aw_target_i = 1; step(); bus.aw_issue_i = 0;
    bus.bid_i[1] = 16'h0033; bus.bresp_i[1] = 2'b01; bus.buser_i[1] = 6'h15; bus.bvalid_i = 4'b0010;
    #1;
    chk("b_valid", bus.bvalid_o, 1);
    chk("b_bid", bus.bid_o, 16'h0033);
    chk("b_brdy_lo", bus.bready_o, 0);
    step(); step(); step();
    bus.bid_i[0] = 16'h0044; bus.bvalid_i = 4'b0011;
    #1;
    chk("b_state", dut.r_state, HOLD);
    chk("b_bid_hold", bus.bid_o, 16'h0033);
    chk("b_bresp_hold", bus.bresp_o, 2'b01);
    chk("b_buser_hold", bus.buser_o, 6'h15);
    chk("b_brdy_hold", bus.bready_o, 0);
    bus.bready_i = 1;
    #1;
    chk("b_brdy1", bus.bready_o, 4'b0010);
    step();
    bus.bvalid_i = 4'b0001;
    #1;
    chk("b_bid0", bus.bid_o, 16'h0044);
    chk("b_brdy0", bus.bready_o, 4'b0001);
    step();
    bus.bvalid_i = '0; bus.bready_i = 0;
    chk("b_cnt0", dut.r_cnt[0], 0);
    chk("b_cnt1", dut.r_cnt[1], 0);
    chk("b_cnt2", dut.r_cnt[2], 1);
    // DECERR waits for port 2's outstanding response
    bus.err_push_i = 1; bus.err_id_i = 16'h00A5; bus.err_user_i = 6'h2A; step();
    bus.err_push_i = 0; step();
    chk("d_blocked", bus.bvalid_o, 0);
    bus.bid_i[2] = 16'h0055; bus.bresp_i[2] = RESP_OKAY; bus.bvalid_i = 4'b0100; bus.bready_i = 1;
    #1;
    chk("d_bid2", bus.bid_o, 16'h0055);
    chk("d_bresp2", bus.bresp_o, RESP_OKAY);
    step();
    bus.bvalid_i = '0;
    #1;
    chk("d_valid", bus.bvalid_o, 1);
    chk("d_bresp", bus.bresp_o, 2'b11);
    chk("d_bid", bus.bid_o, 16'h00A5);
    chk("d_buser", bus.buser_o, 6'h2A);
    chk("d_brdy", bus.bready_o, 0);
    step();
    bus.bready_i = 0;
    chk("d_popped", bus.bvalid_o, 0);
    chk("d_proto", bus.proto_err_o, 0);
    // simultaneous AW and B on port 0 at count 5
    bus.aw_issue_i = 1; bus.aw_target_i = 0;
    for (int i = 0; i < 5; i++) step();
    chk("e_cnt5", dut.r_cnt[0], 5);
    bus.bid_i[0] = 16'h0066; bus.bvalid_i = 4'b0001; bus.bready_i = 1;
    step();
    bus.aw_issue_i = 0; bus.bvalid_i = '0; bus.bready_i = 0;
    chk("e_cnt_same", dut.r_cnt[0], 5);
    chk("e_stall", bus.aw_stall_o, 0);
    chk("e_proto", bus.proto_err_o, 0);
    // five pushes into a 4-deep FIFO with no pops
    bus.err_push_i = 1;
    for (int i = 1; i <= 4; i++) begin
      bus.err_id_i = 16'(i); step();
    end
    chk("f_full", bus.err_full_o, 1);
    chk("f_proto_pre", bus.proto_err_o, 0);
    bus.err_id_i = 16'd5; step();
    bus.err_push_i = 0;
    chk("f_proto", bus.proto_err_o, 1);
    bus.bvalid_i = 4'b0001; bus.bready_i = 1;
    for (int i = 0; i < 5; i++) step();
    bus.bvalid_i = '0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("f_deq_bid", bus.bid_o, 64'(i));
      chk("f_deq_bresp", bus.bresp_o, 2'b11);
      step();
    end
    chk("f_dropped", bus.bvalid_o, 0);
    chk("f_not_full", bus.err_full_o, 0);
    bus.bready_i = 0;
    // reset asserted mid-HOLD
    bus.bvalid_i = 4'b0010; step();
    chk("r_inhold", dut.r_state, HOLD);
    bus.bvalid_i = '0; rst_n = 0;
    #1;
    chk("r_state", dut.r_state, IDLE);
    chk("r_bvalid", bus.bvalid_o, 0);
    chk("r_proto", bus.proto_err_o, 0);
    chk("r_outst", bus.outst_any_o, 0);
    step();
    rst_n = 1;
    step();
    // credit exhaustion on port 3
    bus.aw_issue_i = 1; bus.aw_target_i = 3;
    for (int i = 0; i < 15; i++) step();
    chk("g_stall15", bus.aw_stall_o, 0);
    step();
    chk("g_stall16", bus.aw_stall_o, 4'b1000);
    chk("g_proto16", bus.proto_err_o, 0);
    step();
    bus.aw_issue_i = 0;
    chk("g_proto17", bus.proto_err_o, 1);
    chk("g_cnt17", dut.r_cnt[3], 16);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
